// File: rtl/line_pkg.sv
// Shared definitions for the 10-bit line serializer: symbol width and FSM state encoding.
package line_pkg;

  localparam int SYM_W = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    WAIT_SYM = 2'd2,
    SHIFT    = 2'd3
  } state_e;

endpackage

// File: rtl/bit_tick_gen.sv
// Line-bit timing: div_cnt runs 0..CLK_DIV-1 and flags the first and last clk of each bit.
module bit_tick_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_first_o,
  output logic tick_last_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  assign tick_first_o = (div_cnt_q == '0);
  assign tick_last_o  = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/serializer_10b_s.sv
// Serializes 8b/10b symbols LSB first behind an alternating sync preamble,
// with a one-deep holding register refilled by the encoder on each continue pulse.
module serializer_10b_s
  import line_pkg::*;
#(
  parameter int   CLK_DIV    = 8,
  parameter int   SYNC_BITS  = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [SYM_W-1:0] data_10b,
  input  logic             data_10b_en,
  output logic             encode_continue,
  output logic             tx_bit,
  output logic             bit_strobe,
  output logic             tx_busy,
  output logic             underrun,
  output logic             overrun
);

  localparam int PW = $clog2(SYNC_BITS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SYNC_BITS - 1);
  localparam logic [3:0]    BIT_LAST = 4'(SYM_W - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [SYM_W-1:0]  sr_q, sr_d;
  logic [SYM_W-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic              tx_bit_q, tx_bit_d;
  logic              continue_q;
  logic              load;
  logic              tick_first, tick_last, div_clr;

  // Divider only runs while bits are on the line and restarts on every state change.
  assign div_clr = (state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_SYM);

  bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (div_clr),
    .tick_first_o (tick_first),
    .tick_last_o  (tick_last)
  );

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    load        = 1'b0;
    tx_bit_d    = IDLE_LEVEL;

    case (state_q)
      IDLE: begin
        if (tx_en) begin
          state_d     = PREAMBLE;
          pre_cnt_d   = '0;
          underrun_d  = 1'b0;
          overrun_d   = 1'b0;
          hold_full_d = 1'b0;
        end
      end
      PREAMBLE: begin
        if (!tx_en) begin
          state_d = IDLE;
        end else if (tick_last) begin
          if (pre_cnt_q == PRE_LAST) begin
            if (hold_full_q) begin
              state_d = SHIFT;
              load    = 1'b1;
            end else begin
              state_d = WAIT_SYM;
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
          end
        end
      end
      WAIT_SYM: begin
        if (!tx_en) begin
          state_d = IDLE;
        end else if (hold_full_q) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (tick_last) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (!tx_en) begin
              state_d     = IDLE;
              hold_full_d = 1'b0;
            end else if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d    = WAIT_SYM;
              underrun_d = 1'b1;
            end
          end else begin
            sr_d      = sr_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d        = hold_q;
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
    end

    // A write landing in the same clk as a load refills the freshly drained hold.
    if (data_10b_en && (state_q != IDLE)) begin
      hold_d      = data_10b;
      hold_full_d = 1'b1;
      if (hold_full_q && !load) begin
        overrun_d = 1'b1;
      end
    end

    case (state_d)
      PREAMBLE: tx_bit_d = ~pre_cnt_d[0];
      SHIFT:    tx_bit_d = sr_d[0];
      default:  tx_bit_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_bit_q    <= IDLE_LEVEL;
      continue_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      tx_bit_q    <= tx_bit_d;
      continue_q  <= load;
    end
  end

  assign encode_continue = continue_q;
  assign tx_bit          = tx_bit_q;
  assign bit_strobe      = tick_first && ((state_q == PREAMBLE) || (state_q == SHIFT));
  assign tx_busy         = (state_q != IDLE);
  assign underrun        = underrun_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_serializer_10b_s.sv
// Directed bench for serializer_10b_s: table of symbols with hand-written line bit orders,
// encoder-like feeding of frames, and hand-written underrun/overrun/drop/reset sequences.
module tb_serializer_10b_s;

  localparam int   CLK_DIV    = 4;
  localparam int   SYNC_BITS  = 4;
  localparam logic IDLE_LEVEL = 1'b0;

  logic       clk, rst, tx_en, data_10b_en;
  logic [9:0] data_10b;
  logic       encode_continue, tx_bit, bit_strobe, tx_busy, underrun, overrun;

  serializer_10b_s #(
    .CLK_DIV    (CLK_DIV),
    .SYNC_BITS  (SYNC_BITS),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_en           (tx_en),
    .data_10b        (data_10b),
    .data_10b_en     (data_10b_en),
    .encode_continue (encode_continue),
    .tx_bit          (tx_bit),
    .bit_strobe      (bit_strobe),
    .tx_busy         (tx_busy),
    .underrun        (underrun),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sym;
    string      bits;  // line order, first transmitted bit first
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   bits_q[$];
  int   cont_cnt;
  int   busy_cycles;

  task automatic step();
    @(posedge clk);
    #1;
    if (bit_strobe) bits_q.push_back(tx_bit);
    if (encode_continue) cont_cnt++;
    if (tx_busy) busy_cycles++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic chk_bits(input string nm, input int off, input string exp);
    logic [15:0] a, e;
    a = '0;
    e = '0;
    for (int i = 0; i < exp.len(); i++) begin
      e[i] = (exp.getc(i) == 8'h31);
      a[i] = (off + i < bits_q.size()) ? logic'(bits_q[off + i]) : ~e[i];
    end
    chk(nm, 32'(a), 32'(e));
  endtask

  task automatic clear_rec();
    bits_q.delete();
    cont_cnt    = 0;
    busy_cycles = 0;
  endtask

  task automatic strobe(input logic [9:0] v);
    data_10b    = v;
    data_10b_en = 1'b1;
    step();
    data_10b_en = 1'b0;
  endtask

  task automatic wait_cont(input string nm);
    int c0;
    c0 = cont_cnt;
    for (int i = 0; i < 300 && cont_cnt == c0; i++) step();
    chk({nm, " continue seen"}, (cont_cnt > c0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 600 && tx_busy; i++) step();
    chk({nm, " idle"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " tx_bit"},   32'(tx_bit),          32'(IDLE_LEVEL));
    chk({nm, " busy"},     32'(tx_busy),         32'd0);
    chk({nm, " strobe"},   32'(bit_strobe),      32'd0);
    chk({nm, " continue"}, 32'(encode_continue), 32'd0);
    chk({nm, " underrun"}, 32'(underrun),        32'd0);
    chk({nm, " overrun"},  32'(overrun),         32'd0);
  endtask

  // Encoder-like feed: first symbol during preamble, next ones 4 clks after each continue.
  task automatic run_frame(input int first, input int n);
    string nm;
    clear_rec();
    tx_en = 1'b1;
    step();
    strobe(vecs[first].sym);
    for (int k = 0; k < n; k++) begin
      wait_cont($sformatf("frame%0d sym%0d", first, k));
      if (k < n - 1) begin
        repeat (3) step();
        strobe(vecs[first + k + 1].sym);
      end else begin
        tx_en = 1'b0;
      end
    end
    nm = $sformatf("frame%0d", first);
    wait_idle(nm);
    chk({nm, " bit count"}, 32'(bits_q.size()), 32'(SYNC_BITS + 10 * n));
    chk_bits({nm, " preamble"}, 0, "1010");
    for (int k = 0; k < n; k++)
      chk_bits($sformatf("%s sym%0d bits", nm, k), SYNC_BITS + 10 * k, vecs[first + k].bits);
    chk({nm, " continues"}, 32'(cont_cnt), 32'(n));
    chk({nm, " busy clks (no gap)"}, 32'(busy_cycles), 32'((SYNC_BITS + 10 * n) * CLK_DIV));
    chk({nm, " underrun"}, 32'(underrun), 32'd0);
    chk({nm, " overrun"}, 32'(overrun), 32'd0);
    chk({nm, " idle level"}, 32'(tx_bit), 32'(IDLE_LEVEL));
  endtask

  initial begin
    vecs[0] = '{10'h2A5, "1010010101"};
    vecs[1] = '{10'h17C, "0011111010"};
    vecs[2] = '{10'h0F0, "0000111100"};
    vecs[3] = '{10'h3FF, "1111111111"};
    vecs[4] = '{10'h001, "1000000000"};

    rst = 1'b1; tx_en = 1'b0; data_10b = '0; data_10b_en = 1'b0;
    clear_rec();
    step(); step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Strobe in IDLE is ignored: preamble ends in WAIT_SYM with no load.
    strobe(10'h155);
    clear_rec();
    tx_en = 1'b1;
    repeat (SYNC_BITS * CLK_DIV + 4) step();
    chk("idle strobe ignored continues", 32'(cont_cnt), 32'd0);
    chk("idle strobe ignored busy", 32'(tx_busy), 32'd1);
    chk("wait_sym level", 32'(tx_bit), 32'(IDLE_LEVEL));
    tx_en = 1'b0;
    step();
    chk("wait_sym drop busy", 32'(tx_busy), 32'd0);

    run_frame(0, 1);
    run_frame(1, 3);
    run_frame(4, 1);

    // Late refill: gap at idle level, sticky underrun until next frame start.
    clear_rec();
    tx_en = 1'b1;
    step();
    strobe(vecs[0].sym);
    wait_cont("late A");
    repeat (44) step();
    chk("late underrun", 32'(underrun), 32'd1);
    chk("late gap level", 32'(tx_bit), 32'(IDLE_LEVEL));
    chk("late gap busy", 32'(tx_busy), 32'd1);
    repeat (15) step();
    strobe(vecs[1].sym);
    wait_cont("late B");
    tx_en = 1'b0;
    wait_idle("late");
    chk("late underrun sticky", 32'(underrun), 32'd1);
    chk("late continues", 32'(cont_cnt), 32'd2);
    chk_bits("late sym A", SYNC_BITS, vecs[0].bits);
    chk_bits("late sym B", SYNC_BITS + 10, vecs[1].bits);
    tx_en = 1'b1;
    step();
    chk("underrun cleared on start", 32'(underrun), 32'd0);
    tx_en = 1'b0;
    step();
    chk("preamble drop busy", 32'(tx_busy), 32'd0);

    // Overrun: second write 2 clks later overwrites the full hold.
    clear_rec();
    tx_en = 1'b1;
    step();
    strobe(vecs[2].sym);
    step();
    strobe(vecs[3].sym);
    chk("overrun flag", 32'(overrun), 32'd1);
    wait_cont("overrun");
    tx_en = 1'b0;
    wait_idle("overrun");
    chk_bits("overrun second value sent", SYNC_BITS, vecs[3].bits);
    chk("overrun continues", 32'(cont_cnt), 32'd1);
    chk("overrun sticky", 32'(overrun), 32'd1);

    // tx_en dropped at bit 3: symbol completes, queued hold discarded.
    clear_rec();
    tx_en = 1'b1;
    step();
    strobe(vecs[1].sym);
    wait_cont("drop");
    repeat (3) step();
    strobe(vecs[4].sym);
    for (int i = 0; i < 200 && bits_q.size() < SYNC_BITS + 4; i++) step();
    chk("drop reached bit 3", 32'(bits_q.size()), 32'(SYNC_BITS + 4));
    tx_en = 1'b0;
    wait_idle("drop");
    chk("drop bit count", 32'(bits_q.size()), 32'(SYNC_BITS + 10));
    chk_bits("drop symbol complete", SYNC_BITS, vecs[1].bits);
    chk("drop continues", 32'(cont_cnt), 32'd1);
    chk("drop idle level", 32'(tx_bit), 32'(IDLE_LEVEL));

    // Reset mid-SHIFT, then restart.
    clear_rec();
    tx_en = 1'b1;
    step();
    strobe(vecs[0].sym);
    wait_cont("midrst");
    repeat (8) step();
    rst = 1'b1;
    tx_en = 1'b0;
    step();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step();
    chk("midrst stays idle", 32'(tx_busy), 32'd0);
    tx_en = 1'b1;
    step();
    chk("restart busy", 32'(tx_busy), 32'd1);
    chk("restart strobe", 32'(bit_strobe), 32'd1);
    chk("restart first preamble bit", 32'(tx_bit), 32'd1);
    tx_en = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
